// File: rtl/sakebi_arb_pkg.sv
// Shared definitions for the sakebi requester-sharing blocks:
// arbiter state encoding and the grant-index width helper.
package sakebi_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int gw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sakebi_rr_pick.sv
// Rotating-priority picker: first asserted request at or after rr_ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module sakebi_rr_pick
    import sakebi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = gw_of(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    int k;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = IW'(k);
            end
        end
    end

endmodule

// File: rtl/sakebi_fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one async-FIFO write port.
// A grant lasts until `last` or MAX_BURST beats, then priority rotates.
module sakebi_fifo_wr_arbiter
    import sakebi_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    localparam int GW = gw_of(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic                          o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
    input  logic                          i_fifo_wr_ready,
    output logic                          o_busy,
    output logic [GW-1:0]                 o_grant_id,
    output logic                          o_burst_cut
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    state, state_nxt;
    logic [GW-1:0] grant, grant_nxt;
    logic [GW-1:0] rr_ptr, rr_nxt;
    logic [CW-1:0] beat_cnt, cnt_nxt;
    logic          burst_cut, cut_nxt;

    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic          at_limit;
    logic [GW-1:0] grant_inc;

    sakebi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (i_req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    // Datapath follows the registered grant; nothing is exposed in IDLE.
    always_comb begin
        o_fifo_wr_data = i_req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
        o_req_ready    = '0;
        o_fifo_wr_en   = 1'b0;
        if (state == XFER) begin
            o_req_ready[grant] = i_fifo_wr_ready;
            o_fifo_wr_en       = i_req_valid[grant] & i_fifo_wr_ready;
        end
    end

    assign at_limit  = (beat_cnt == CW'(MAX_BURST - 1));
    assign grant_inc = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        cut_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable && pick_found) begin
                    grant_nxt = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (o_fifo_wr_en) begin
                    // last wins over the limit, so a coincident end is not a cut
                    if (i_req_last[grant] || at_limit) begin
                        state_nxt = IDLE;
                        rr_nxt    = grant_inc;
                        cut_nxt   = ~i_req_last[grant];
                    end else begin
                        cnt_nxt = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            burst_cut <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_nxt;
            beat_cnt  <= cnt_nxt;
            burst_cut <= cut_nxt;
        end
    end

    assign o_busy      = (state == XFER);
    assign o_grant_id  = grant;
    assign o_burst_cut = burst_cut;

endmodule

// File: tb/tb_sakebi_fifo_wr_arbiter.sv
// Directed bench for sakebi_fifo_wr_arbiter with a per-cycle reference
// model of the grant rules and literal checks on write/grant logs.
module tb_sakebi_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;
    localparam int SD = 64;

    logic            clk = 1'b0;
    logic            rst, en, rdy;
    logic [N-1:0]    req_valid, req_last, hold;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wr_en, busy, burst_cut;
    logic [DW-1:0]   wr_data;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    sakebi_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en),
        .i_req_valid(req_valid), .i_req_last(req_last), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data),
        .i_fifo_wr_ready(rdy), .o_busy(busy), .o_grant_id(grant_id),
        .o_burst_cut(burst_cut)
    );

    // requester sources: per-requester beat store, head popped on handshake
    logic [DW-1:0] src_data [N][SD];
    logic          src_last [N][SD];
    int            src_head [N];
    int            src_tail [N];

    // logs of what the DUT actually did
    int      wcnt, gcnt, ccnt, cyc;
    logic [DW-1:0] wlog_data [256];
    int      wlog_src [256];
    int      wlog_cyc [256];
    int      glog [64];
    int      clog_cyc [16];
    logic    prev_busy;

    // model state
    bit      m_busy, m_cut;
    int      m_owner, m_sent, m_next;

    int chk_m, fail_m, chk_d, fail_d;

    task automatic cmp_m(input string name, input int act, input int exp);
        chk_m++;
        if (act != exp) begin
            fail_m++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic cmp_d(input string name, input int act, input int exp);
        chk_d++;
        if (act != exp) begin
            fail_d++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load(input int k, input int n, input int d0);
        for (int j = 0; j < n; j++) begin
            src_data[k][src_tail[k]] = DW'(d0 + j);
            src_last[k][src_tail[k]] = (j == n - 1);
            src_tail[k]++;
        end
    endtask

    // driver + compare + model, one step per cycle
    initial begin
        wcnt = 0; gcnt = 0; ccnt = 0; cyc = 0; prev_busy = 1'b0;
        m_busy = 0; m_cut = 0; m_owner = 0; m_sent = 0; m_next = 0;
        chk_m = 0; fail_m = 0;
        for (int k = 0; k < N; k++) begin src_head[k] = 0; src_tail[k] = 0; end
        req_valid = '0; req_last = '0; req_data = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                req_valid[k] = (src_head[k] < src_tail[k]) && !hold[k];
                req_last[k]  = src_last[k][src_head[k] % SD];
                req_data[k*DW +: DW] = src_data[k][src_head[k] % SD];
            end
            #2;
            cyc++;
            begin
                logic [N-1:0] e_ready;
                bit e_wr;
                e_ready = '0;
                e_wr = 0;
                if (m_busy) begin
                    e_ready[m_owner] = rdy;
                    e_wr = req_valid[m_owner] && rdy;
                end
                cmp_m("busy", int'(busy), int'(m_busy));
                cmp_m("grant_id", int'(grant_id), m_owner);
                cmp_m("req_ready", int'(req_ready), int'(e_ready));
                cmp_m("wr_en", int'(wr_en), int'(e_wr));
                cmp_m("burst_cut", int'(burst_cut), int'(m_cut));
                if (!rdy) cmp_m("wr_en_stalled", int'(wr_en), 0);
                if (e_wr) cmp_m("wr_data", int'(wr_data), int'(req_data[m_owner*DW +: DW]));

                if (wr_en) begin
                    wlog_data[wcnt] = wr_data;
                    wlog_src[wcnt]  = int'(grant_id);
                    wlog_cyc[wcnt]  = cyc;
                    wcnt++;
                end
                if (burst_cut) begin clog_cyc[ccnt % 16] = cyc; ccnt++; end
                if (busy && !prev_busy) begin glog[gcnt % 64] = int'(grant_id); gcnt++; end
                prev_busy = busy;
                for (int k = 0; k < N; k++)
                    if (req_valid[k] && req_ready[k]) src_head[k]++;

                if (rst) begin
                    m_busy = 0; m_cut = 0; m_owner = 0; m_sent = 0; m_next = 0;
                end else begin
                    m_cut = 0;
                    if (!m_busy) begin
                        if (en && |req_valid) begin
                            for (int i = N - 1; i >= 0; i--)
                                if (req_valid[(m_next + i) % N]) m_owner = (m_next + i) % N;
                            m_busy = 1;
                            m_sent = 0;
                        end
                    end else if (e_wr) begin
                        m_sent++;
                        if (req_last[m_owner] || m_sent == MB) begin
                            m_cut  = !req_last[m_owner];
                            m_busy = 0;
                            m_next = (m_owner + 1) % N;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_writes(input int base, input int n);
        int t;
        t = 0;
        while (wcnt - base < n && t < 300) begin @(posedge clk); #1; t++; end
        if (wcnt - base < n) cmp_d("wait_writes_timeout", wcnt - base, n);
    endtask

    task automatic wait_drain();
        int t;
        bit pend;
        t = 0;
        pend = 1;
        while (pend && t < 400) begin
            @(posedge clk); #1; t++;
            pend = busy;
            for (int k = 0; k < N; k++) if (src_head[k] < src_tail[k]) pend = 1;
        end
        if (pend) cmp_d("drain_timeout", t, 0);
    endtask

    int bw, bg;

    initial begin
        chk_d = 0; fail_d = 0;
        rst = 1'b1; en = 1'b1; rdy = 1'b1; hold = '0;
        #1;
        // reset with every requester valid; req0 queues a second packet
        load(0, 3, 8'h00); load(1, 3, 8'h10); load(2, 3, 8'h20); load(3, 3, 8'h30);
        load(0, 3, 8'h03);
        repeat (2) @(posedge clk);
        #1;
        cmp_d("rst_busy", int'(busy), 0);
        cmp_d("rst_ready", int'(req_ready), 0);
        cmp_d("rst_wr_en", int'(wr_en), 0);
        cmp_d("rst_grant_id", int'(grant_id), 0);
        rst = 1'b0;

        // fairness: 0,1,2,3,0 with one idle cycle between 3-beat packets
        wait_drain();
        cmp_d("fair_writes", wcnt, 15);
        cmp_d("fair_g0", glog[0], 0);
        cmp_d("fair_g1", glog[1], 1);
        cmp_d("fair_g2", glog[2], 2);
        cmp_d("fair_g3", glog[3], 3);
        cmp_d("fair_g4", glog[4], 0);
        cmp_d("fair_contig", wlog_cyc[2] - wlog_cyc[0], 2);
        cmp_d("fair_gap", wlog_cyc[3] - wlog_cyc[2], 2);
        cmp_d("fair_span", wlog_cyc[14] - wlog_cyc[0], 18);
        cmp_d("fair_d3", int'(wlog_data[3]), 'h10);
        cmp_d("fair_d12", int'(wlog_data[12]), 'h03);
        cmp_d("model_rr_fair", m_next, 1);

        // burst cut: 20 beats from req2 -> 16 + cut pulse, idle, then 4
        bw = wcnt; bg = gcnt;
        load(2, 20, 8'h80);
        wait_drain();
        cmp_d("cut_writes", wcnt - bw, 20);
        cmp_d("cut_pulses", ccnt, 1);
        cmp_d("cut_pulse_cyc", clog_cyc[0], wlog_cyc[bw + 15] + 1);
        cmp_d("cut_gap", wlog_cyc[bw + 16] - wlog_cyc[bw + 15], 2);
        cmp_d("cut_grants", gcnt - bg, 2);
        cmp_d("cut_src", wlog_src[bw + 19], 2);
        cmp_d("cut_last_data", int'(wlog_data[bw + 19]), 'h93);

        // backpressure 1,0,0,1 in the middle of a 6-beat packet
        bw = wcnt; bg = gcnt;
        load(3, 6, 8'hC0);
        wait_writes(bw, 2);
        rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rdy = 1'b1;
        wait_drain();
        cmp_d("bp_writes", wcnt - bw, 6);
        cmp_d("bp_stall", wlog_cyc[bw + 2] - wlog_cyc[bw + 1], 3);
        cmp_d("bp_grants", gcnt - bg, 1);
        for (int j = 0; j < 6; j++) cmp_d("bp_order", int'(wlog_data[bw + j]), 'hC0 + j);

        // quiesce: enable drops on beat 2, packet still completes
        bw = wcnt; bg = gcnt;
        load(0, 5, 8'hA0); load(1, 3, 8'hB0); load(2, 3, 8'hD0);
        wait_writes(bw, 1);
        en = 1'b0;
        wait_writes(bw, 5);
        repeat (6) @(posedge clk);
        #1;
        cmp_d("quiesce_busy", int'(busy), 0);
        cmp_d("quiesce_writes", wcnt - bw, 5);
        cmp_d("quiesce_grants", gcnt - bg, 1);
        en = 1'b1;
        wait_drain();
        cmp_d("resume_g1", glog[bg + 1], 1);
        cmp_d("resume_g2", glog[bg + 2], 2);
        cmp_d("resume_writes", wcnt - bw, 11);

        // reset during req1's 6-beat packet; rr_ptr restarts at 0
        bw = wcnt; bg = gcnt;
        load(1, 6, 8'h50);
        wait_writes(bw, 3);
        rst = 1'b1;
        load(0, 2, 8'h60);
        @(posedge clk);
        #1;
        cmp_d("mid_rst_busy", int'(busy), 0);
        cmp_d("model_rr_rst", m_next, 0);
        rst = 1'b0;
        wait_drain();
        cmp_d("mid_rst_g0", glog[bg], 1);
        cmp_d("mid_rst_g1", glog[bg + 1], 0);
        cmp_d("mid_rst_g2", glog[bg + 2], 1);
        cmp_d("mid_rst_writes", wcnt - bw, 8);
        cmp_d("mid_rst_beat4", int'(wlog_data[bw + 3]), 'h53);
        cmp_d("mid_rst_req0", int'(wlog_data[bw + 4]), 'h60);

        // 4-cycle valid gap: req2 keeps the grant, req3 waits
        bw = wcnt; bg = gcnt;
        load(2, 4, 8'h70); load(3, 2, 8'h78);
        wait_writes(bw, 1);
        hold[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        hold[2] = 1'b0;
        wait_drain();
        cmp_d("gap_len", wlog_cyc[bw + 1] - wlog_cyc[bw], 5);
        for (int j = 0; j < 4; j++) cmp_d("gap_src_req2", wlog_src[bw + j], 2);
        cmp_d("gap_src_req3", wlog_src[bw + 4], 3);
        cmp_d("gap_writes", wcnt - bw, 6);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 chk_m + chk_d, fail_m + fail_d);
        $finish;
    end

endmodule

// File: doc/sakebi_fifo_wr_arbiter.md
Name: sakebi_fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single write port of an async FIFO between NUM_REQ requesters in the write-clock domain.
- Holds a grant for a whole packet (until `last`) or until MAX_BURST beats, then rotates priority.
- Supports an enable for quiescing, and flags bursts that were cut by the limit.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- DATA_WIDTH, 8, beat width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 16, maximum beats per grant (≥1).

Ports:
- i_clk  in  1  write-side clock, same as the FIFO write clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  1 = new grants allowed; 0 = finish the current grant, then idle.
- i_req_valid  in  NUM_REQ  per-requester beat valid.
- i_req_last  in  NUM_REQ  per-requester end-of-packet marker, qualified by valid.
- i_req_data  in  NUM_REQ*DATA_WIDTH  requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_req_ready  out  NUM_REQ  per-requester beat accepted when valid & ready.
- o_fifo_wr_en  out  1  to FIFO i_wr_en.
- o_fifo_wr_data  out  DATA_WIDTH  to FIFO i_wr_data.
- i_fifo_wr_ready  in  1  from FIFO o_wr_ready (not full).
- o_busy  out  1  grant active.
- o_grant_id  out  GW  current/last granted requester; GW = max(1, $clog2(NUM_REQ)).
- o_burst_cut  out  1  one-cycle pulse when a grant ends on MAX_BURST without `last`.

Behaviour:
- Reset (i_rst=1 at a posedge):
  - state=IDLE; rr_ptr=0; beat_cnt=0; grant=0.
  - o_busy=0, o_grant_id=0, o_burst_cut=0.
  - o_req_ready=0 and o_fifo_wr_en=0 (combinational, follow the state).
  - Reset mid-packet abandons the grant; already-written beats stay in the FIFO.
- States: IDLE, XFER.
- IDLE:
  - No ready, no write enable.
  - If i_enable & |i_req_valid, select the first valid index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Register the winner into grant, set beat_cnt=0, go to XFER.
  - Arbitration costs exactly one cycle: the first beat is accepted no earlier than the cycle after the request is seen.
- XFER, datapath (combinational from registered grant g):
  - o_fifo_wr_data = i_req_data[g].
  - o_req_ready[g] = i_fifo_wr_ready; all other ready bits = 0.
  - o_fifo_wr_en = i_req_valid[g] & i_fifo_wr_ready.
  - A beat is accepted when o_fifo_wr_en=1. The block never asserts o_fifo_wr_en while i_fifo_wr_ready=0.
- XFER, beat accounting:
  - Each accepted beat increments beat_cnt.
  - Valid dropping mid-packet inserts bubbles only; the grant is held indefinitely (no timeout).
- XFER exit (on an accepted beat):
  - If i_req_last[g]=1, or beat_cnt==MAX_BURST-1: go to IDLE and set rr_ptr = (g+1) mod NUM_REQ.
  - If the exit is caused by the limit while last=0, pulse o_burst_cut for 1 cycle (registered, the cycle after).
  - If last and the limit coincide, last takes precedence: no cut pulse.
  - The remainder of a cut packet re-arbitrates as a new burst.
- Timing and state outputs:
  - Minimum one IDLE cycle between consecutive grants, even with continuous requests.
  - Single-beat packets give 50% throughput; this is by design.
  - o_busy = (state==XFER); o_grant_id = grant register (holds after exit).
- i_enable:
  - Sampled only in IDLE.
  - Deassertion during XFER does not truncate the grant.
- Wrap-around:
  - rr_ptr wraps NUM_REQ-1 → 0; the scan wraps likewise.
  - beat_cnt width $clog2(MAX_BURST+1); it never exceeds MAX_BURST-1.

Decomposition:
- Shared package sakebi_arb_pkg holds:
  - state encoding localparams (IDLE=1'b0, XFER=1'b1);
  - the GW width helper function.
- Sub-module sakebi_rr_pick: purely combinational rotating-priority picker.
  - Inputs: request vector and rr_ptr.
  - Outputs: found flag and index.
  - Instantiated once; reusable by other requester-sharing blocks.

Test Plan:
- Reset and idle: i_rst=1 for 2 cycles with all valids high → o_busy=0, o_req_ready=0, o_fifo_wr_en=0; the first grant after release goes to req0.
- Fairness: NUM_REQ=4, all valid, 3-beat packets, FIFO always ready → grant order 0,1,2,3,0; each packet gives 3 consecutive writes; 1 idle cycle between packets.
- Burst cut: req2 alone sends a 20-beat packet with MAX_BURST=16 → 16 writes, o_burst_cut pulses once; after 1 idle cycle, 4 more writes with no cut pulse.
- Backpressure: i_fifo_wr_ready toggled 1,0,0,1 mid-packet → no o_fifo_wr_en while ready=0; data order is preserved and beat_cnt is unchanged during stalls.
- Enable quiesce: i_enable=0 asserted on the 2nd beat of a 5-beat packet → all 5 beats are written, then o_busy stays 0 while requests are pending; re-enable → grant resumes at rr_ptr.
- Mid-packet reset and bubbles:
  - Reset on beat 3 of 6 → next cycle o_busy=0, rr_ptr=0.
  - Requester valid gap of 4 cycles → grant held, no other requester served.
